// File: rtl/grng_pkg.sv
// grng_pkg: shared constants, sample type and helpers for the Gaussian stream buffer.
// Rev 1.0
`default_nettype none

package grng_pkg;

  localparam int GRNG_W   = 16;
  localparam int GRNG_LAT = 6;

  typedef logic signed [15:0] gsample_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/grng_sync_fifo.sv
// grng_sync_fifo: first-word-fall-through synchronous FIFO, occupancy counter is the only full/empty source.
// Rev 1.0
`default_nettype none

module grng_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout  = empty ? '0 : mem[rd_ptr];
  assign level = cnt;

endmodule

`default_nettype wire

// File: rtl/grng_stream_buf.sv
// grng_stream_buf: owns the ICDF generator enable, drops pipeline warm-up output and buffers samples
// onto a valid/ready stream. Rev 1.0
`default_nettype none

module grng_stream_buf
  import grng_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int LAT       = GRNG_LAT,
  parameter int W         = GRNG_W,
  parameter bit MARGIN_EN = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run,
  output logic                   en_icdf,
  input  logic [W-1:0]           gauss_in,
  output logic [W-1:0]           dout,
  output logic                   dout_valid,
  input  logic                   dout_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic [15:0]            drop_cnt
);

  localparam int LW  = $clog2(DEPTH) + 1;
  localparam int WCW = $clog2(LAT + 1);

  logic [WCW-1:0] wc;
  logic           afull;
  logic           cap;
  logic           pop;
  logic           fifo_empty;
  logic           fifo_full;
  logic           drop;

  // Two-entry margin: one sample is already in flight when the registered enable drops.
  assign afull = MARGIN_EN ? (level >= LW'(DEPTH - 2)) : 1'b0;
  assign cap   = en_icdf & (wc == WCW'(LAT));
  assign pop   = dout_valid & dout_ready;
  assign drop  = cap & fifo_full & ~pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_icdf  <= 1'b0;
      wc       <= '0;
      drop_cnt <= '0;
    end else begin
      en_icdf <= run & ~afull;
      if (!en_icdf)
        wc <= '0;
      else if (wc != WCW'(LAT))
        wc <= wc + WCW'(1);
      if (drop)
        drop_cnt <= sat_inc16(drop_cnt);
    end
  end

  grng_sync_fifo #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cap),
    .din   (gauss_in),
    .pop   (pop),
    .dout  (dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (level)
  );

  assign dout_valid = ~fifo_empty;

endmodule

`default_nettype wire
